// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the 32-point MDC FFT front end.
package fft_pkg;

    localparam int FFT_N        = 32;
    localparam int HALF_N       = 16;
    localparam int IDX_W        = 5;
    localparam int STATE_CODE_W = 7;
    localparam int ROM16_W      = 4;

    // Input assembler states: waiting for a frame, expecting even / odd sample.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVEN = 2'd1,
        ST_ODD  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fft_input_ctrl.sv
// Front-end control of the 32-point MDC FFT: pairs even/odd samples of a
// serial stream onto two lanes and generates the stage-1 control words.
module fft_input_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [WIDTH-1:0]        in_re,
    input  logic [WIDTH-1:0]        in_im,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_ui_re,
    output logic [WIDTH-1:0]        out_ui_im,
    output logic [WIDTH-1:0]        out_li_re,
    output logic [WIDTH-1:0]        out_li_im,
    output logic [STATE_CODE_W-1:0] state_code,
    output logic [ROM16_W-1:0]      rom_16_counter,
    output logic                    frame_done,
    output logic                    err
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_N - 1);

    fsm_state_t              state, state_nxt;
    logic [IDX_W-1:0]        idx;       // index of the next sample to accept
    logic [WIDTH-1:0]        hold_re, hold_im;
    logic [STATE_CODE_W-1:0] pair_cnt;  // pairs emitted since frame start

    // Control decoded from the current state and input strobe
    logic ld_hold;    // latch the incoming sample as the even half of a pair
    logic restart;    // incoming sample is index 0 of a new frame
    logic emit;       // incoming sample completes a pair
    logic clr_cnt;    // fresh frame out of IDLE restarts the pair count
    logic set_err;    // start marker landed mid-frame

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and datapath control
    always_comb begin
        state_nxt = state;
        ld_hold   = 1'b0;
        restart   = 1'b0;
        emit      = 1'b0;
        clr_cnt   = 1'b0;
        set_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    ld_hold   = 1'b1;
                    restart   = 1'b1;
                    clr_cnt   = 1'b1;
                    state_nxt = ST_ODD;
                end
            end
            ST_EVEN: begin
                if (in_valid) begin
                    ld_hold   = 1'b1;
                    restart   = in_sof;
                    // a marker exactly on the frame boundary is the normal case
                    set_err   = in_sof && (idx != '0);
                    state_nxt = ST_ODD;
                end
            end
            ST_ODD: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // drop the held even sample, re-anchor on this one
                        ld_hold   = 1'b1;
                        restart   = 1'b1;
                        set_err   = 1'b1;
                        state_nxt = ST_ODD;
                    end else begin
                        emit      = 1'b1;
                        state_nxt = ST_EVEN;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sample index, hold register and running pair count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            hold_re  <= '0;
            hold_im  <= '0;
            pair_cnt <= '0;
        end else begin
            if (restart)              idx <= IDX_W'(1);
            else if (ld_hold || emit) idx <= idx + 1'b1;
            if (ld_hold) begin
                hold_re <= in_re;
                hold_im <= in_im;
            end
            if (clr_cnt)   pair_cnt <= '0;
            else if (emit) pair_cnt <= pair_cnt + 1'b1;
        end
    end

    // Output register: data and control words launched together with the pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_ui_re      <= '0;
            out_ui_im      <= '0;
            out_li_re      <= '0;
            out_li_im      <= '0;
            state_code     <= '0;
            rom_16_counter <= '0;
            frame_done     <= 1'b0;
        end else begin
            out_valid  <= emit;
            frame_done <= emit && (idx == IDX_LAST);
            if (emit) begin
                out_ui_re      <= hold_re;
                out_ui_im      <= hold_im;
                out_li_re      <= in_re;
                out_li_im      <= in_im;
                state_code     <= pair_cnt;
                rom_16_counter <= idx[IDX_W-1:1];
            end
        end
    end

    // Sticky protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err <= 1'b0;
        else if (set_err) err <= 1'b1;
    end

endmodule

// File: doc/fft_input_ctrl.md
# fft_input_ctrl

Front-end control stage of the 32-point MDC FFT, directly upstream of the first butterfly stage. It accepts a serial complex sample stream at up to one sample per cycle and assembles 32-sample frames into two-lane pairs: even-indexed samples go to the upper lane (UI) and odd-indexed samples to the lower lane (LI). It also generates the stage-1 control words `state_code` and `rom_16_counter`, aligned with each emitted pair. Frame alignment comes from a start-of-frame marker, and malformed frames are flagged.

## Interface
- `WIDTH`, 9, sample component width (two's complement).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input sample strobe.
- `in_sof`  in  1  start of frame; qualified by `in_valid`; marks sample index 0.
- `in_re`, `in_im`  in  WIDTH  input sample.
- `out_valid`  out  1  pair strobe to stage 1.
- `out_ui_re`, `out_ui_im`  out  WIDTH  upper-lane sample, x[2k].
- `out_li_re`, `out_li_im`  out  WIDTH  lower-lane sample, x[2k+1].
- `state_code`  out  7  emitted-pair counter.
- `rom_16_counter`  out  4  twiddle index for stage 1.
- `frame_done`  out  1  one-cycle pulse with the 16th pair of a frame.
- `err`  out  1  sticky protocol-error flag.

## Operation
- FSM states:
  - IDLE: waits for `in_valid & in_sof`; all samples without `in_sof` are dropped.
  - EVEN: the next accepted sample has an even index; it is latched into the hold register.
  - ODD: the next accepted sample completes the pair, and the pair is emitted.
- 5-bit sample index `idx`:
  - `in_valid & in_sof` forces `idx=0` and moves to ODD after latching the sample.
  - Each accepted sample increments `idx` and wraps 31→0.
- Emission: when the ODD sample is accepted, the registered outputs take UI=hold and LI=current sample, and `out_valid=1` for one cycle.
- `state_code`: 7-bit count of emitted pairs; increments after each emission and wraps 127→0. It is reset to 0 by `in_sof` arriving from IDLE.
- `rom_16_counter` = pair index within the frame, which is `idx[4:1]` of the completing sample (0..15). It is registered alongside the data.
- `frame_done`: asserted with the pair where `idx=31`.
- Frame boundary after `idx=31`: the FSM returns to EVEN.
  - A following `in_sof` is legal and expected.
  - A sample at `idx=0` without `in_sof` is accepted as a continuing frame.
- Mid-frame `in_sof` (`idx≠0`):
  - The current partial pair is discarded and `err` is set.
  - The `in_sof` sample becomes index 0 of a new frame.
  - `state_code` is not cleared.
- Gaps (`in_valid=0`) are allowed anywhere. The hold register and `idx` are retained, and no output is produced.
- `err` clears only on `rst`.
- Data is passed through unmodified; no arithmetic is performed. Output data holds its last value when `out_valid=0`.

## Timing
- Reset values:
  - FSM=IDLE, `idx=0`, hold register = 0.
  - All data outputs = 0; `out_valid=0`, `state_code=0`, `rom_16_counter=0`, `frame_done=0`, `err=0`.
- Latency: `out_valid` rises exactly 1 cycle after the cycle that accepts the odd sample.
- Throughput: 1 sample/cycle in, and 1 pair every 2 cycles out.
- `rst` asserted mid-frame immediately clears all state. The partial frame is lost and no pair is emitted.
- `in_sof` while `in_valid=0` is ignored.

## Structure
- Shared package `fft_pkg`:
  - `FFT_N=32`, `HALF_N=16`.
  - `IDX_W=5`, `STATE_CODE_W=7`, `ROM16_W=4`.
  - The FSM state enum.
- Single module with no sub-modules. The hold register, index counter, FSM and output register are all local.

## Test plan
- Reset, then `in_sof` plus samples 1..32 (re=n, im=−n) back to back:
  - 16 pairs, with pair k UI=(2k+1, −(2k+1)) and LI=(2k+2, −(2k+2)).
  - `rom_16_counter` runs 0..15 and `state_code` runs 0..15.
  - `frame_done` pulses with pair 15; `err=0`.
- Same frame with `in_valid` toggled every other cycle: the pair contents and counters are identical, and each `out_valid` comes 1 cycle after its odd sample.
- Samples before the first `in_sof`: they are ignored, no `out_valid`, `err=0`.
- `in_sof` at `idx=7`: the partial pair is discarded, `err=1` and stays 1, and the next pair has `rom_16_counter=0`.
- Eight consecutive frames: `state_code` wraps 127→0 at pair 128 with no error.
- `rst` asserted after 5 samples, then a clean frame: all outputs are 0 during reset, and the first pair after the new `in_sof` has `state_code=0`.
